// File: rtl/mem_pkg.sv
// Shared definitions for the sram-like memory port: master ids, size codes, lock states, request payload.
package mem_pkg;

  localparam logic MST_INST = 1'b0;
  localparam logic MST_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    LOCK_I,
    LOCK_D
  } lock_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_order_fifo.sv
// Synchronous FIFO of 1-bit master ids recording issue order of accepted transactions.
module arb_order_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           din,
  output logic                           dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_en;
  logic             pop_en;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  // A same-cycle pop never makes room for a push: push only checks current fullness.
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push_en, pop_en})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Arbitrates the IF-stage and EX-stage sram-like masters onto one shared port and routes
// in-order responses back by master id.
module sram_like_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   inst_req,
  input  logic                                   inst_wr,
  input  logic [1:0]                             inst_size,
  input  logic [3:0]                             inst_wstrb,
  input  logic [31:0]                            inst_addr,
  input  logic [31:0]                            inst_wdata,
  output logic                                   inst_addr_ok,
  output logic                                   inst_data_ok,
  output logic [31:0]                            inst_rdata,
  input  logic                                   data_req,
  input  logic                                   data_wr,
  input  logic [1:0]                             data_size,
  input  logic [3:0]                             data_wstrb,
  input  logic [31:0]                            data_addr,
  input  logic [31:0]                            data_wdata,
  output logic                                   data_addr_ok,
  output logic                                   data_data_ok,
  output logic [31:0]                            data_rdata,
  output logic                                   bus_req,
  output logic                                   bus_wr,
  output logic [1:0]                             bus_size,
  output logic [3:0]                             bus_wstrb,
  output logic [31:0]                            bus_addr,
  output logic [31:0]                            bus_wdata,
  input  logic                                   bus_addr_ok,
  input  logic                                   bus_data_ok,
  input  logic [31:0]                            bus_rdata,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   err_spurious
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  lock_t         lock_q;
  lock_t         lock_d;
  logic [SW-1:0] starve_q;
  logic          sel;
  logic          gnt_req;
  logic          accept;
  logic          full;
  logic          empty;
  logic          head;
  logic          resp;
  mem_req_t      inst_pl;
  mem_req_t      data_pl;
  mem_req_t      bus_pl;

  assign inst_pl = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb, addr: inst_addr, wdata: inst_wdata};
  assign data_pl = '{wr: data_wr, size: data_size, wstrb: data_wstrb, addr: data_addr, wdata: data_wdata};

  always_ff @(posedge clk) begin
    if (!resetn) lock_q <= IDLE;
    else         lock_q <= lock_d;
  end

  // Grant selection and lock next-state; registered state only, so addr_ok is a pure pass-through.
  always_comb begin
    lock_d  = lock_q;
    sel     = MST_INST;
    gnt_req = 1'b0;
    case (lock_q)
      LOCK_I: begin
        sel     = MST_INST;
        gnt_req = inst_req;
      end
      LOCK_D: begin
        sel     = MST_DATA;
        gnt_req = data_req;
      end
      default: begin
        if (inst_req && (starve_q == SW'(STARVE_LIMIT))) begin
          sel     = MST_INST;
          gnt_req = 1'b1;
        end else if (data_req) begin
          sel     = MST_DATA;
          gnt_req = 1'b1;
        end else begin
          sel     = MST_INST;
          gnt_req = inst_req;
        end
      end
    endcase

    bus_req = resetn & gnt_req & ~full;
    accept  = bus_req & bus_addr_ok;

    case (lock_q)
      LOCK_I:  if (accept || !inst_req) lock_d = IDLE;
      LOCK_D:  if (accept || !data_req) lock_d = IDLE;
      default: if (bus_req && !bus_addr_ok) lock_d = (sel == MST_DATA) ? LOCK_D : LOCK_I;
    endcase
  end

  assign bus_pl       = (sel == MST_DATA) ? data_pl : inst_pl;
  assign bus_wr       = bus_pl.wr;
  assign bus_size     = bus_pl.size;
  assign bus_wstrb    = bus_pl.wstrb;
  assign bus_addr     = bus_pl.addr;
  assign bus_wdata    = bus_pl.wdata;
  assign inst_addr_ok = accept & (sel == MST_INST);
  assign data_addr_ok = accept & (sel == MST_DATA);

  // Counts data wins while inst is waiting; saturation forces the next inst grant.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_q <= '0;
    end else if (accept && (sel == MST_INST)) begin
      starve_q <= '0;
    end else if (accept && inst_req && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_q <= starve_q + SW'(1);
    end
  end

  arb_order_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .pop    (bus_data_ok),
    .din    (sel),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .count  (outstanding)
  );

  assign resp         = resetn & bus_data_ok & ~empty;
  assign inst_data_ok = resp & (head == MST_INST);
  assign data_data_ok = resp & (head == MST_DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  always_ff @(posedge clk) begin
    if (!resetn)                   err_spurious <= 1'b0;
    else if (bus_data_ok && empty) err_spurious <= 1'b1;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter: expected master ids queued at accept, checked at response.
module tb_sram_like_arbiter;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, bus_size;
  logic [3:0]  inst_wstrb, data_wstrb, bus_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [1:0]  outstanding;
  logic        err_spurious;

  int errors = 0;
  int checks = 0;
  logic sb [$];

  always #5 clk = ~clk;

  sram_like_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .outstanding(outstanding), .err_spurious(err_spurious)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end
    step();
    step();
    inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    resetn = 1'b1;
    step();
    checks++;
    if (outstanding !== 2'd0 || err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: outstanding=%0d err=%b expected 0 0", outstanding, err_spurious);
    end
  endtask

  task automatic test_priority_and_order();
    logic exp;
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    data_req = 1'b1; data_addr = 32'h00000100;
    bus_addr_ok = 1'b1;
    @(negedge clk);
    checks++;
    if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0 || bus_addr !== 32'h00000100) begin
      errors++;
      $display("FAIL prio_cycle0: data_ok=%b inst_ok=%b addr=%h expected 1 0 00000100",
               data_addr_ok, inst_addr_ok, bus_addr);
    end
    if (data_addr_ok === 1'b1) sb.push_back(MST_DATA);
    step();
    data_req = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_addr_ok !== 1'b1 || bus_addr !== 32'h1c000000) begin
      errors++;
      $display("FAIL prio_cycle1: inst_ok=%b addr=%h expected 1 1c000000", inst_addr_ok, bus_addr);
    end
    if (inst_addr_ok === 1'b1) sb.push_back(MST_INST);
    step();
    inst_req = 1'b0; bus_addr_ok = 1'b0;
    checks++;
    if (outstanding !== 2'd2) begin
      errors++;
      $display("FAIL prio_outstanding: got %0d expected 2", outstanding);
    end
    bus_data_ok = 1'b1; bus_rdata = 32'hAAAA0000;
    @(negedge clk);
    exp = (sb.size() != 0) ? sb.pop_front() : MST_INST;
    checks++;
    if (exp !== MST_DATA || data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== 32'hAAAA0000) begin
      errors++;
      $display("FAIL order_resp0: data_ok=%b inst_ok=%b rdata=%h expected 1 0 aaaa0000",
               data_data_ok, inst_data_ok, data_rdata);
    end
    step();
    bus_rdata = 32'h5555FFFF;
    @(negedge clk);
    exp = (sb.size() != 0) ? sb.pop_front() : MST_DATA;
    checks++;
    if (exp !== MST_INST || inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'h5555FFFF) begin
      errors++;
      $display("FAIL order_resp1: inst_ok=%b data_ok=%b rdata=%h expected 1 0 5555ffff",
               inst_data_ok, data_data_ok, inst_rdata);
    end
    step();
    bus_data_ok = 1'b0;
    checks++;
    if (outstanding !== 2'd0) begin
      errors++;
      $display("FAIL order_drained: outstanding=%0d expected 0", outstanding);
    end
  endtask

  task automatic test_starvation();
    logic exp;
    logic want;
    inst_req = 1'b1; inst_addr = 32'h1c000010;
    data_req = 1'b1; data_addr = 32'h00000200;
    bus_addr_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin
        inst_req = 1'b0; data_req = 1'b0;
      end
      bus_data_ok = (sb.size() != 0);
      bus_rdata   = $urandom;
      @(negedge clk);
      if (bus_data_ok) begin
        exp = sb.pop_front();
        checks++;
        if ((exp == MST_INST && (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== bus_rdata)) ||
            (exp == MST_DATA && (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== bus_rdata))) begin
          errors++;
          $display("FAIL starve_resp%0d: inst_ok=%b data_ok=%b expected id %b", i,
                   inst_data_ok, data_data_ok, exp);
        end
      end
      if (i < 6) begin
        want = (i == 4) ? MST_INST : MST_DATA;
        checks++;
        if (inst_addr_ok !== (want == MST_INST) || data_addr_ok !== (want == MST_DATA)) begin
          errors++;
          $display("FAIL starve_grant%0d: inst_ok=%b data_ok=%b expected winner %b", i,
                   inst_addr_ok, data_addr_ok, want);
        end
        sb.push_back(want);
      end
      step();
    end
    bus_data_ok = 1'b0; bus_addr_ok = 1'b0;
    checks++;
    if (outstanding !== 2'd0 || sb.size() != 0) begin
      errors++;
      $display("FAIL starve_drained: outstanding=%0d queued=%0d expected 0 0", outstanding, sb.size());
    end
  endtask

  task automatic test_full();
    logic exp;
    data_req = 1'b1; data_addr = 32'h00000300; bus_addr_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (data_addr_ok === 1'b1) sb.push_back(MST_DATA);
      step();
    end
    bus_data_ok = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b0 || data_addr_ok !== 1'b0) begin
      errors++;
      $display("FAIL full_block: bus_req=%b addr_ok=%b expected 0 0", bus_req, data_addr_ok);
    end
    exp = (sb.size() != 0) ? sb.pop_front() : MST_INST;
    checks++;
    if (exp !== MST_DATA || data_data_ok !== 1'b1) begin
      errors++;
      $display("FAIL full_pop: data_ok=%b expected 1", data_data_ok);
    end
    step();
    bus_data_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1 || data_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL full_next: bus_req=%b addr_ok=%b expected 1 1", bus_req, data_addr_ok);
    end
    if (data_addr_ok === 1'b1) sb.push_back(MST_DATA);
    step();
    data_req = 1'b0; bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    while (sb.size() != 0) begin
      bus_rdata = $urandom;
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (data_data_ok !== (exp == MST_DATA) || inst_data_ok !== (exp == MST_INST) || data_rdata !== bus_rdata) begin
        errors++;
        $display("FAIL full_drain: data_ok=%b inst_ok=%b expected id %b", data_data_ok, inst_data_ok, exp);
      end
      step();
    end
    bus_data_ok = 1'b0;
  endtask

  task automatic test_lock();
    logic exp;
    data_req = 1'b1; data_addr = 32'h00000400; bus_addr_ok = 1'b0;
    inst_req = 1'b0; inst_addr = 32'h1c000040;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) inst_req = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_req !== 1'b1 || bus_addr !== 32'h00000400 || inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
        errors++;
        $display("FAIL lock_hold%0d: bus_req=%b addr=%h expected 1 00000400", i, bus_req, bus_addr);
      end
      step();
    end
    data_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b0) begin
      errors++;
      $display("FAIL lock_withdraw: bus_req=%b expected 0", bus_req);
    end
    step();
    bus_addr_ok = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_addr !== 32'h1c000040 || inst_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL lock_inst_grant: addr=%h inst_ok=%b expected 1c000040 1", bus_addr, inst_addr_ok);
    end
    if (inst_addr_ok === 1'b1) sb.push_back(MST_INST);
    step();
    inst_req = 1'b0; bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    exp = (sb.size() != 0) ? sb.pop_front() : MST_DATA;
    checks++;
    if (exp !== MST_INST || inst_data_ok !== 1'b1 || inst_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL lock_resp: inst_ok=%b rdata=%h expected 1 cafef00d", inst_data_ok, inst_rdata);
    end
    step();
    bus_data_ok = 1'b0;
  endtask

  task automatic test_spurious();
    bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 || err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL spur_same: inst_ok=%b data_ok=%b err=%b expected 0 0 0",
               inst_data_ok, data_data_ok, err_spurious);
    end
    step();
    bus_data_ok = 1'b0;
    checks++;
    if (err_spurious !== 1'b1 || outstanding !== 2'd0) begin
      errors++;
      $display("FAIL spur_set: err=%b outstanding=%0d expected 1 0", err_spurious, outstanding);
    end
    data_req = 1'b1; bus_addr_ok = 1'b1;
    step();
    data_req = 1'b0; bus_addr_ok = 1'b0;
    step();
    checks++;
    if (err_spurious !== 1'b1 || outstanding !== 2'd1) begin
      errors++;
      $display("FAIL spur_sticky: err=%b outstanding=%0d expected 1 1", err_spurious, outstanding);
    end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    sb.delete();
    checks++;
    if (err_spurious !== 1'b0 || outstanding !== 2'd0) begin
      errors++;
      $display("FAIL spur_reset: err=%b outstanding=%0d expected 0 0", err_spurious, outstanding);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    inst_wr = 1'b0; inst_size = SIZE_W; inst_wstrb = 4'h0; inst_addr = '0; inst_wdata = '0;
    data_wr = 1'b0; data_size = SIZE_W; data_wstrb = 4'hf; data_addr = '0; data_wdata = 32'h0badc0de;
    bus_rdata = '0;
    test_reset();
    test_priority_and_order();
    test_starvation();
    test_full();
    test_lock();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
